// File: rtl/mygo_chan_recv.sv
// Receive endpoint for a lowered Go channel: turns a level receive request into one
// valid/ready handshake on the FIFO output. Optional timeout: MYGO_CHAN_RECV_TIMEOUT_EN.
module mygo_chan_recv #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_BITS = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ch_data,
    input  logic             ch_valid,
    output logic             ch_ready,
    input  logic             recv_req,
    output logic             recv_done,
    output logic [WIDTH-1:0] recv_data,
    output logic             recv_ok,
    output logic             busy,
    output logic [31:0]      recv_count,
    output logic [1:0]       dbg_state
);

    // Handshake: an element transfers on a rising edge where ch_valid and ch_ready are both 1.
    // ch_ready is a decode of the WAIT state only, so it never depends on ch_valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ok_q, ok_d;
    logic [31:0]      count_q, count_d;
    logic             handshake;
    logic             timeout_hit;

    assign handshake = (state_q == S_WAIT) && ch_valid;

`ifdef MYGO_CHAN_RECV_TIMEOUT_EN
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

    // Cleared while idle so it starts from zero on every entry to WAIT.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if ((state_q == S_WAIT) && !handshake) begin
            to_cnt_d = to_cnt_q + TO_BITS'(1);
        end
    end

    assign timeout_hit = (state_q == S_WAIT) && !ch_valid &&
                         (to_cnt_q == TO_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ok_d    = ok_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (recv_req) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (handshake) begin
                    data_d  = ch_data;
                    ok_d    = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    ok_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ok_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            count_q <= count_d;
        end
    end

    assign ch_ready   = (state_q == S_WAIT);
    assign recv_done  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign recv_data  = data_q;
    assign recv_ok    = ok_q;
    assign recv_count = count_q;
    assign dbg_state  = state_q;

endmodule
